// File: rtl/pipe_adder_if.sv
// Stream bundle for pipe_adder: operation request side and result side.
// The slave modport is the adder's view; the master modport is the driver's view.
interface pipe_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES carry-linked segments,
// one segment resolved per stage, with a global valid/ready stall.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic advance;

    // Index k carries the operation as it enters stage k: operands, completed
    // low result segments, incoming carry and valid.
    logic [STAGES-1:0][WIDTH-1:0] a_link;
    logic [STAGES-1:0][WIDTH-1:0] b_link;
    logic [STAGES-1:0][WIDTH-1:0] s_link;
    logic [STAGES-1:0]            c_link;
    logic [STAGES-1:0]            v_link;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Subtraction is folded in at entry, so later stages never see the op tag.
    assign a_link[0] = bus.a;
    assign b_link[0] = bus.sub ? ~bus.b : bus.b;
    assign c_link[0] = bus.sub ? 1'b1 : bus.cin;
    assign s_link[0] = '0;
    assign v_link[0] = bus.in_valid && advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]   a_seg;
        logic [SEG-1:0]   b_seg;
        logic [SEG:0]     seg_sum;
        logic [WIDTH-1:0] s_d;

        assign a_seg   = SEG'(a_link[k] >> (k * SEG));
        assign b_seg   = SEG'(b_link[k] >> (k * SEG));
        assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_link[k]};

        // NOTE: always_comb assigns every output first, so no path can infer a latch.
        always_comb begin
            s_d                  = s_link[k];
            s_d[k*SEG +: SEG]    = seg_sum[SEG-1:0];
        end

        if (k < LAST) begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            // NOTE: registers take <= so every stage samples pre-edge values of its neighbour.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= v_link[k];
                end
            end

            // NOTE: intermediate datapath is left unreset; v_q alone qualifies it.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_link[k];
                    b_q <= b_link[k];
                    s_q <= s_d;
                    c_q <= seg_sum[SEG];
                end
            end

            assign a_link[k+1] = a_q;
            assign b_link[k+1] = b_q;
            assign s_link[k+1] = s_q;
            assign c_link[k+1] = c_q;
            assign v_link[k+1] = v_q;
        end else begin : g_last
            logic [WIDTH-1:0] sum_q;
            logic             cout_q;
            logic             ovf_q;
            logic             ovf_d;
            logic             out_valid_q;

            assign ovf_d = (a_link[k][WIDTH-1] == b_link[k][WIDTH-1])
                        && (s_d[WIDTH-1] != a_link[k][WIDTH-1]);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    cout_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                end else if (advance) begin
                    out_valid_q <= v_link[k];
                    sum_q       <= s_d;
                    cout_q      <= seg_sum[SEG];
                    ovf_q       <= ovf_d;
                end
            end

            assign bus.out_valid = out_valid_q;
            assign bus.sum       = sum_q;
            assign bus.cout      = cout_q;
            assign bus.ovf       = ovf_q;
        end
    end
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three configurations (8/2, 32/4, 16/1) checked against
// an arithmetic reference model using unsigned/signed range rules.
module tb_pipe_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(8))  if8 ();
    pipe_adder_if #(.WIDTH(32)) if32 ();
    pipe_adder_if #(.WIDTH(16)) if16 ();

    pipe_adder #(.WIDTH(8),  .STAGES(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    pipe_adder #(.WIDTH(32), .STAGES(4)) u32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    pipe_adder #(.WIDTH(16), .STAGES(1)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    int n_vec = 0;
    int n_err = 0;
    int w_of[3] = '{8, 32, 16};
    int s_of[3] = '{2, 4, 1};

    function automatic longint sx(input int w, input longint v);
        return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
    endfunction

    // Returns {ovf, cout, sum}: cout means unsigned overflow (add) or no borrow (sub),
    // ovf means the exact signed result does not fit in w bits.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
        longint mask, ua, ub, full, sr;
        logic co, of;
        mask = (longint'(1) << w) - 1;
        ua   = longint'({32'd0, a}) & mask;
        ub   = longint'({32'd0, b}) & mask;
        if (sub) begin
            full = ua - ub;
            co   = (ua >= ub);
            sr   = sx(w, ua) - sx(w, ub);
        end else begin
            full = ua + ub + (cin ? 1 : 0);
            co   = (full > mask);
            sr   = sx(w, ua) + sx(w, ub) + (cin ? 1 : 0);
        end
        of = (sr > (longint'(1) << (w - 1)) - 1) || (sr < -(longint'(1) << (w - 1)));
        return {of, co, 32'(full & mask)};
    endfunction

    task automatic drive(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        case (id)
            0: begin if8.in_valid = v;  if8.a = a[7:0];   if8.b = b[7:0];   if8.cin = cin;  if8.sub = sub;  end
            1: begin if32.in_valid = v; if32.a = a;       if32.b = b;       if32.cin = cin; if32.sub = sub; end
            default: begin if16.in_valid = v; if16.a = a[15:0]; if16.b = b[15:0]; if16.cin = cin; if16.sub = sub; end
        endcase
    endtask

    task automatic sample(input int id, output logic ov, output logic [31:0] s, output logic co,
                          output logic of, output logic ir);
        case (id)
            0: begin ov = if8.out_valid;  s = 32'(if8.sum);  co = if8.cout;  of = if8.ovf;  ir = if8.in_ready;  end
            1: begin ov = if32.out_valid; s = if32.sum;      co = if32.cout; of = if32.ovf; ir = if32.in_ready; end
            default: begin ov = if16.out_valid; s = 32'(if16.sum); co = if16.cout; of = if16.ovf; ir = if16.in_ready; end
        endcase
    endtask

    task automatic test_reset();
        logic ov, co, of, ir;
        logic [31:0] s;
        rst_n = 1'b0;
        for (int id = 0; id < 3; id++) drive(id, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        if8.out_ready = 1'b1; if32.out_ready = 1'b1; if16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int id = 0; id < 3; id++) begin
            sample(id, ov, s, co, of, ir);
            n_vec++;
            if ({ov, co, of, s, ir} !== {3'b000, 32'd0, 1'b1}) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got valid=%b cout=%b ovf=%b sum=%h in_ready=%b, expected 0 0 0 0 1",
                         id, ov, co, of, s, ir);
            end
        end
    endtask

    task automatic run_op(input int id, input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
        logic ov, co, of, ir;
        logic [31:0] s;
        logic [33:0] exp;
        int lat;
        exp = ref_op(w_of[id], a, b, cin, sub);
        @(negedge clk);
        drive(id, 1'b1, a, b, cin, sub);
        #1 sample(id, ov, s, co, of, ir);
        n_vec++;
        if (ir !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready: got %b expected 1", name, ir);
        end
        @(posedge clk);
        #1 drive(id, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            sample(id, ov, s, co, of, ir);
        end while (ov !== 1'b1 && lat < 20);
        n_vec++;
        if (lat != s_of[id]) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, lat, s_of[id]);
        end
        n_vec++;
        if ({of, co, s} !== exp) begin
            n_err++;
            $display("FAIL %s result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                     name, of, co, s, exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic test_directed();
        run_op(0, "w8_ff_plus_01", 32'hFF, 32'h01, 1'b0, 1'b0);
        run_op(0, "w8_7f_plus_01", 32'h7F, 32'h01, 1'b0, 1'b0);
        run_op(0, "w8_sub_cin_ignored", 32'h05, 32'h07, 1'b1, 1'b1);
        run_op(1, "w32_carry_chain", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(1, "w32_sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1);
        run_op(2, "w16_all_ones_cin", 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0);
    endtask

    task automatic test_random_ops();
        for (int id = 0; id < 3; id++) begin
            for (int i = 0; i < 4; i++) begin
                run_op(id, "random_op", $urandom, $urandom, 1'($urandom), 1'($urandom));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] q[$];
        logic [33:0] held_val, exp;
        logic held;
        logic ov, co, of, ir, r, v, c, sb;
        logic [31:0] s, a, b;
        int sent, got, cyc, extra;
        held = 1'b0; sent = 0; got = 0; cyc = 0; extra = 0;
        while (got < 16 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            r  = ($urandom_range(0, 2) != 0);
            v  = (sent < 16) && ($urandom_range(0, 3) != 0);
            a  = $urandom; b = $urandom; c = 1'($urandom); sb = 1'($urandom);
            drive(0, v, a, b, c, sb);
            if8.out_ready = r;
            #1 sample(0, ov, s, co, of, ir);
            n_vec++;
            if (ir !== (!ov || r)) begin
                n_err++;
                $display("FAIL stream in_ready: got %b expected %b (cycle %0d)", ir, !ov || r, cyc);
            end
            if (held) begin
                n_vec++;
                if ({ov, of, co, s} !== {1'b1, held_val}) begin
                    n_err++;
                    $display("FAIL stream hold: got valid=%b %h expected valid=1 %h", ov, {of, co, s}, held_val);
                end
            end
            if (ov && r) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream extra_result: got %h expected none", {of, co, s});
                end else begin
                    exp = q.pop_front();
                    if ({of, co, s} !== exp) begin
                        n_err++;
                        $display("FAIL stream result %0d: got %h expected %h", got, {of, co, s}, exp);
                    end
                end
                got++;
                held = 1'b0;
            end else if (ov) begin
                held = 1'b1;
                held_val = {of, co, s};
            end
            if (v && ir) begin
                q.push_back(ref_op(8, a, b, c, sb));
                sent++;
            end
        end
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        if8.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (if8.out_valid === 1'b1) extra++;
        end
        n_vec++;
        if (got != 16 || q.size() != 0 || extra != 0) begin
            n_err++;
            $display("FAIL stream count: got %0d results, %0d left, %0d extra; expected 16, 0, 0",
                     got, q.size(), extra);
        end
    endtask

    task automatic test_reset_midstream();
        logic ov, co, of, ir;
        logic [31:0] s;
        int seen;
        @(negedge clk);
        if8.out_ready = 1'b0;
        drive(0, 1'b1, 32'h12, 32'h34, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 32'h56, 32'h21, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 sample(0, ov, s, co, of, ir);
        n_vec++;
        if (ov !== 1'b1 || s !== 32'h47) begin
            n_err++;
            $display("FAIL midreset_precondition: got valid=%b sum=%h expected valid=1 sum=47", ov, s);
        end
        rst_n = 1'b0;
        if8.out_ready = 1'b1;
        drive(0, 1'b1, 32'h33, 32'h44, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1 sample(0, ov, s, co, of, ir);
        n_vec++;
        if ({ov, co, of, s, ir} !== {3'b000, 32'd0, 1'b1}) begin
            n_err++;
            $display("FAIL midreset_state: got valid=%b cout=%b ovf=%b sum=%h in_ready=%b expected 0 0 0 0 1",
                     ov, co, of, s, ir);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (if8.out_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL midreset_flush: got %0d valid cycles expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_ops();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
